// File: rtl/keypad_emulator.sv
// keypad_emulator: injects key presses into a 4x3 keypad matrix; define KEYEMU_BOUNCE_EN for contact bounce at press start
module keypad_emulator #(
  parameter int HOLD_CYCLES   = 1000,
  parameter int GAP_CYCLES    = 1000,
  parameter int BOUNCE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  input  logic       B,
  input  logic       G,
  input  logic       F,
  input  logic       D,
  output logic       C,
  output logic       A,
  output logic       E,
  output logic       busy,
  output logic       err
);
  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;
  localparam int MAXC = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW = MAXC > 1 ? $clog2(MAXC) : 1;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] key_q, key_d;
  logic err_q, err_d;
  logic row, act, en;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      key_q   <= 4'd13;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (key_valid) begin
        key_d   = key_code;
        cnt_d   = CW'(HOLD_CYCLES - 1);
        state_d = key_code < 4'd12 ? PRESS : IDLE;
        err_d   = key_code >= 4'd12;
      end
      PRESS: begin
        cnt_d   = cnt_q == '0 ? CW'(GAP_CYCLES - 1) : cnt_q - 1'b1;
        state_d = cnt_q == '0 ? GAP : PRESS;
      end
      GAP: begin
        cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
        state_d = cnt_q == '0 ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
  end
`ifdef KEYEMU_BOUNCE_EN
  localparam int BW = BOUNCE_CYCLES > 0 ? $clog2(BOUNCE_CYCLES + 1) : 1;
  logic [BW-1:0] b_q, b_d;
  // b_q counts cycles spent in PRESS, saturating at the end of the bounce window
  always_ff @(posedge clk) begin
    if (!rst_n) b_q <= '0;
    else b_q <= b_d;
  end
  always_comb begin
    b_d = state_q != PRESS ? '0 : (b_q < BW'(BOUNCE_CYCLES) ? b_q + 1'b1 : b_q);
    en  = b_q >= BW'(BOUNCE_CYCLES) ? 1'b1 : ~b_q[0];
  end
`else
  assign en = 1'b1;
`endif
  // row-to-column path stays combinational: the scanner samples in the cycle it drives
  always_comb begin
    row = key_q inside {4'd1, 4'd2, 4'd3} ? B :
          key_q inside {4'd4, 4'd5, 4'd6} ? G :
          key_q inside {4'd7, 4'd8, 4'd9} ? F : D;
    act = state_q == PRESS && row && en;
    C   = act && key_q inside {4'd1, 4'd4, 4'd7, 4'd10};
    A   = act && key_q inside {4'd2, 4'd5, 4'd8, 4'd0};
    E   = act && key_q inside {4'd3, 4'd6, 4'd9, 4'd11};
  end
  assign key_ready = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign err       = err_q;
endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: directed stimulus with a queue-based scoreboard for keypad_emulator
module tb_keypad_emulator;
  localparam int HOLD = 20;
  localparam int GAP = 10;
  localparam int BOUNCE = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic B = 1'b0, G = 1'b0, F = 1'b0, D = 1'b0;
  logic key_ready, C, A, E, busy, err;
  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q[$];
  string name_q[$];
  keypad_emulator #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .BOUNCE_CYCLES(BOUNCE)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .B(B), .G(G), .F(F), .D(D),
    .C(C), .A(A), .E(E), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  // expected vector layout: {key_ready, busy, err, C, A, E}
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [5:0] e, got;
      string nm;
      e = exp_q.pop_front();
      nm = name_q.pop_front();
      got = {key_ready, busy, err, C, A, E};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s: got {rdy,busy,err,C,A,E}=%b expected %b at %0t", nm, got, e, $time);
      end
    end
  end
  function automatic logic bm(int i);
`ifdef KEYEMU_BOUNCE_EN
    return i >= BOUNCE ? 1'b1 : ~i[0];
`else
    return 1'b1;
`endif
  endfunction
  task automatic step(input logic v, input logic [3:0] code, input logic [3:0] rows,
                      input logic r, input logic [5:0] e, input string nm);
    @(posedge clk);
    #1;
    key_valid = v;
    key_code = code;
    {B, G, F, D} = rows;
    rst_n = r;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask
  // accept cycle, HOLD press cycles, GAP release cycles; an invalid code is held on the bus throughout
  task automatic press(input logic [3:0] code, input logic [3:0] rows, input logic [2:0] cols,
                       input string nm);
    step(1'b1, code, rows, 1'b1, 6'b100000, {nm, "_acc"});
    for (int i = 0; i < HOLD; i++)
      step(1'b1, 4'd14, rows, 1'b1, {3'b010, cols & {3{bm(i)}}}, {nm, "_press"});
    for (int i = 0; i < GAP; i++)
      step(1'b1, 4'd14, rows, 1'b1, 6'b010000, {nm, "_gap"});
  endtask
  initial begin
    step(1'b0, 4'd0, 4'b1000, 1'b0, 6'b100000, "reset0");
    step(1'b0, 4'd0, 4'b1000, 1'b0, 6'b100000, "reset1");
    step(1'b0, 4'd0, 4'b1000, 1'b1, 6'b100000, "reset_rel");
    press(4'd5, 4'b0100, 3'b010, "k5_G");
    press(4'd5, 4'b1001, 3'b000, "k5_BD");
    press(4'd5, 4'b1111, 3'b010, "k5_all");
    press(4'd11, 4'b0001, 3'b001, "k11_D");
    press(4'd10, 4'b0001, 3'b100, "k10_D");
    press(4'd0, 4'b1111, 3'b010, "k0_all");
    press(4'd1, 4'b1000, 3'b100, "k1_B");
    press(4'd9, 4'b1101, 3'b000, "k9_noF");
    step(1'b0, 4'd0, 4'b1111, 1'b1, 6'b100000, "idle_after");
    step(1'b1, 4'd14, 4'b1111, 1'b1, 6'b100000, "inv14_acc");
    step(1'b0, 4'd0, 4'b1111, 1'b1, 6'b101000, "inv14_err");
    step(1'b1, 4'd12, 4'b1111, 1'b1, 6'b100000, "inv12_acc");
    step(1'b0, 4'd0, 4'b1111, 1'b1, 6'b101000, "inv12_err");
    step(1'b0, 4'd0, 4'b1111, 1'b1, 6'b100000, "inv_clr");
    step(1'b1, 4'd7, 4'b0010, 1'b1, 6'b100000, "k7_acc");
    for (int i = 0; i < 4; i++)
      step(1'b0, 4'd0, 4'b0010, 1'b1, {3'b010, 3'b100 & {3{bm(i)}}}, "k7_press");
    step(1'b0, 4'd0, 4'b0010, 1'b0, {3'b010, 3'b100 & {3{bm(4)}}}, "k7_rst_cycle");
    step(1'b0, 4'd0, 4'b0010, 1'b0, 6'b100000, "k7_rst_idle");
    step(1'b0, 4'd0, 4'b0010, 1'b1, 6'b100000, "k7_rst_rel");
    press(4'd3, 4'b1000, 3'b001, "k3_B");
    step(1'b0, 4'd0, 4'b1111, 1'b1, 6'b100000, "final_idle");
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
